amba3_axi_ram_slave: RTL and testbench
======================================

AMBA3_AXI_RAM_SLAVE -- requirements
Module: amba3_axi_ram_slave

Interface
REQ-001 SHALL have parameter TXID_BITS, default 4, ID width of all channels.
REQ-002 SHALL have parameter ADDR_BITS, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_BITS, default 32, data width; legal values are 32, 64 and 128; STRB_BITS = DATA_BITS/8.
REQ-004 SHALL have parameter MEM_WORDS, default 1024, memory depth in DATA_BITS words; must be a power of two.
REQ-005 aclk  input  1  sole clock; all logic is rising-edge.
REQ-006 areset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 AW channel (awid, awaddr, awlen[3:0], awsize[2:0], awburst, awlock, awcache, awprot, awvalid): inputs; awready: output.
REQ-008 W channel (wid, wdata, wstrb, wlast, wvalid): inputs; wready: output.
REQ-009 B channel (bid, bresp, bvalid): outputs; bready: input.
REQ-010 AR channel (arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid): inputs; arready: output.
REQ-011 R channel (rid, rdata, rresp, rlast, rvalid): outputs; rready: input.
REQ-012 SHALL use the pkg_amba3 enum types for burst, lock, cache, prot and resp.

Function
REQ-013 Write FSM states: W_IDLE -> W_DATA -> W_RESP -> W_IDLE; one write burst in flight at a time.
REQ-014 In W_IDLE, awready = 1; an AW handshake latches ID, address, len, size and burst, then moves to W_DATA.
REQ-015 In W_DATA, wready = 1; each W handshake writes the byte lanes with wstrb = 1 at the current word, then advances the address; the beat counter runs 0..awlen.
REQ-016 The burst ends after exactly awlen+1 beats, regardless of wlast; the FSM then enters W_RESP.
REQ-017 In W_RESP: bvalid = 1 and bid = the latched ID; the FSM holds until bready, then returns to W_IDLE with bvalid = 0 on the next cycle.
REQ-018 Read FSM states: R_IDLE -> R_DATA -> R_IDLE; it runs independently of, and concurrently with, the write FSM.
REQ-019 In R_IDLE, arready = 1; an AR handshake latches the request.
REQ-020 The first rvalid SHALL assert exactly 1 cycle after the AR handshake, i.e. registered memory read.
REQ-021 Each R beat holds rid, rdata, rresp and rlast stable while rvalid = 1 and rready = 0.
REQ-022 rlast = 1 only on beat arlen; after that beat's handshake, rvalid drops and the FSM returns to R_IDLE.
REQ-023 Successive beats SHALL be back-to-back when rready is held high: one beat per cycle.
REQ-024 Address generation, per beat:
- FIXED: address unchanged.
- INCR: address += 2^size.
- WRAP: address += 2^size, wrapping within an aligned (len+1)*2^size region.
REQ-025 Word index = addr >> log2(STRB_BITS); index >= MEM_WORDS means out of range.
REQ-026 Error responses, per burst (write) or per beat (read), highest priority first:
- DECERR: address out of range; no memory update.
- SLVERR: size > log2(STRB_BITS), or WRAP with len not in {1,3,7,15}, or reserved burst type; no memory update.
- SLVERR (write only): any beat wid != latched ID, or wlast asserted on any beat other than the final one, or wlast missing on the final beat; the memory update still occurs.
- Otherwise OKAY.
REQ-027 Exclusive lock SHALL return OKAY; there is no exclusive monitor.
REQ-028 When a read and a write target the same word in the same cycle, the read SHALL return the pre-write data.
REQ-029 The write path SHALL NOT accept W beats before the AW handshake.

Reset
REQ-030 While areset_n = 0: awready, wready, arready, bvalid and rvalid are 0; bid, rid and rdata are 0; bresp and rresp are OKAY; rlast is 0; both FSMs are in their IDLE state.
REQ-031 Reset asserted mid-burst SHALL abandon the burst without any response; memory beats already written are retained.
REQ-032 Memory contents SHALL NOT be reset.
REQ-033 The first handshake accepted after deassertion SHALL occur no earlier than the first rising edge with areset_n = 1.

Structure
REQ-034 The burst_type_t, resp_type_t, lock/cache/prot types and the legal-wrap-length constant SHALL live in pkg_amba3.
REQ-035 The address generator SHALL be the sub-module amba3_axi_burst_addr (inputs addr, len, size, burst, step; output next addr), instanced once each for the write and read paths.
REQ-036 The memory is an inferred array of MEM_WORDS x DATA_BITS with per-byte write enables.

Verification
REQ-037 INCR write then read: AW addr 0x100, len 3, size 2, data 1..4 with wstrb 0xF; then AR of the same burst -> bresp OKAY; rdata 1,2,3,4; rlast only on beat 3.
REQ-038 WRAP read: AR addr 0x10C, len 3, size 2 -> words read in order 0x10C, 0x100, 0x104, 0x108; rresp OKAY.
REQ-039 Strobe merge: preload 0xAABBCCDD, write 0x11223344 with wstrb 0x5 -> read returns 0xAA22CC44.
REQ-040 Errors:
- Write at addr MEM_WORDS*STRB_BITS -> bresp DECERR and memory unchanged.
- Read with size 3 on 32-bit data -> rresp SLVERR on every beat.
- Early wlast on beat 1 of a len-3 burst -> bresp SLVERR after 4 beats.
REQ-041 Backpressure: rready toggles every cycle and bready is held 0 for 5 cycles -> R outputs stay stable while stalled; bvalid stays 1 until bready; no beat is lost or duplicated.
REQ-042 Reset mid-burst: areset_n pulsed low after beat 1 of a len-7 write -> all valids/readies are 0 during reset; the next write completes with OKAY; earlier beats remain in memory.

Source files
------------

// File: rtl/pkg_amba3.sv
// Shared AMBA3 AXI types for the RAM slave: burst/response/lock/cache/prot
// encodings, the legal WRAP length set, FSM state types and a burst legality
// helper used by both the write and read paths.
package pkg_amba3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_type_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_type_t;

    typedef enum logic [1:0] {
        LOCK_NORMAL    = 2'd0,
        LOCK_EXCLUSIVE = 2'd1,
        LOCK_LOCKED    = 2'd2,
        LOCK_RSVD      = 2'd3
    } lock_type_t;

    typedef struct packed {
        logic write_alloc;
        logic read_alloc;
        logic cacheable;
        logic bufferable;
    } cache_t;

    typedef struct packed {
        logic instruction;
        logic nonsecure;
        logic privileged;
    } prot_t;

    // Bit n set means a WRAP burst with len == n is legal (len 1, 3, 7, 15).
    localparam logic [15:0] WRAP_LEN_LEGAL = 16'h808A;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    // True when the burst shape cannot be served: oversize beat, reserved
    // burst type, or a WRAP length outside the legal set.
    function automatic logic burst_is_illegal(input logic [3:0]  len,
                                              input logic [2:0]  size,
                                              input logic [2:0]  max_size,
                                              input burst_type_t burst);
        return (size > max_size) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !WRAP_LEN_LEGAL[len]);
    endfunction

endpackage

// File: rtl/amba3_axi_burst_addr.sv
// Next-beat address generator for FIXED / INCR / WRAP bursts.
// Ports: i_addr current beat address, i_len/i_size/i_burst burst shape,
//        i_step advance request, o_next_addr next address (i_addr when idle).
module amba3_axi_burst_addr
    import pkg_amba3::*;
#(
    parameter int ADDR_BITS = 32
) (
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [3:0]           i_len,
    input  logic [2:0]           i_size,
    input  burst_type_t          i_burst,
    input  logic                 i_step,
    output logic [ADDR_BITS-1:0] o_next_addr
);

    logic [ADDR_BITS-1:0] w_sum;
    logic [ADDR_BITS-1:0] w_wrap_mask;

    assign w_sum = i_addr + (ADDR_BITS'(1) << i_size);
    // Wrap region is (len+1) beats of 2^size bytes, aligned to its own size.
    assign w_wrap_mask = ((ADDR_BITS'(i_len) + ADDR_BITS'(1)) << i_size) - ADDR_BITS'(1);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the output unassigned; that is what keeps always_comb from inferring a latch.
        o_next_addr = i_addr;
        if (i_step) begin
            case (i_burst)
                BURST_INCR: o_next_addr = w_sum;
                BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_sum & w_wrap_mask);
                default:    o_next_addr = i_addr;
            endcase
        end
    end

endmodule

// File: rtl/amba3_axi_ram_slave.sv
// AXI3 slave backed by an inferred single-clock RAM with byte enables.
// Ports: i_aclk / i_areset_n clock and async active-low reset;
//        AW/W/B write channels (one burst in flight), AR/R read channels
//        (independent of writes, registered read, one beat per cycle).
module amba3_axi_ram_slave
    import pkg_amba3::*;
#(
    parameter int TXID_BITS = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic                   i_aclk,
    input  logic                   i_areset_n,
    input  logic [TXID_BITS-1:0]   i_awid,
    input  logic [ADDR_BITS-1:0]   i_awaddr,
    input  logic [3:0]             i_awlen,
    input  logic [2:0]             i_awsize,
    input  burst_type_t            i_awburst,
    input  lock_type_t             i_awlock,
    input  cache_t                 i_awcache,
    input  prot_t                  i_awprot,
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [TXID_BITS-1:0]   i_wid,
    input  logic [DATA_BITS-1:0]   i_wdata,
    input  logic [DATA_BITS/8-1:0] i_wstrb,
    input  logic                   i_wlast,
    input  logic                   i_wvalid,
    output logic                   o_wready,
    output logic [TXID_BITS-1:0]   o_bid,
    output resp_type_t             o_bresp,
    output logic                   o_bvalid,
    input  logic                   i_bready,
    input  logic [TXID_BITS-1:0]   i_arid,
    input  logic [ADDR_BITS-1:0]   i_araddr,
    input  logic [3:0]             i_arlen,
    input  logic [2:0]             i_arsize,
    input  burst_type_t            i_arburst,
    input  lock_type_t             i_arlock,
    input  cache_t                 i_arcache,
    input  prot_t                  i_arprot,
    input  logic                   i_arvalid,
    output logic                   o_arready,
    output logic [TXID_BITS-1:0]   o_rid,
    output logic [DATA_BITS-1:0]   o_rdata,
    output resp_type_t             o_rresp,
    output logic                   o_rlast,
    output logic                   o_rvalid,
    input  logic                   i_rready
);

    localparam int          STRB_BITS = DATA_BITS / 8;
    localparam int          LANE_BITS = $clog2(STRB_BITS);
    localparam int          IDX_BITS  = $clog2(MEM_WORDS);
    localparam logic [2:0]  MAX_SIZE  = 3'(LANE_BITS);

    function automatic logic f_oor(input logic [ADDR_BITS-1:0] a);
        return (a >> LANE_BITS) >= ADDR_BITS'(MEM_WORDS);
    endfunction

    function automatic logic [IDX_BITS-1:0] f_idx(input logic [ADDR_BITS-1:0] a);
        return IDX_BITS'(a >> LANE_BITS);
    endfunction

    logic [DATA_BITS-1:0] r_mem [MEM_WORDS];

    // Readies stay low until the first clock edge after reset release.
    logic r_hs_enable;

    // Lock, cache and prot are accepted but do not affect behaviour; exclusive
    // accesses simply get OKAY.
    logic w_unused;
    assign w_unused = ^{i_awlock, i_awcache, i_awprot, i_arlock, i_arcache, i_arprot};

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values regardless of statement order.
        if (!i_areset_n) r_hs_enable <= 1'b0;
        else             r_hs_enable <= 1'b1;
    end

    // ---------------- write path ----------------
    wr_state_t            r_wstate, w_wstate_next;
    logic [TXID_BITS-1:0] r_wid;
    logic [ADDR_BITS-1:0] r_waddr, w_wnext, w_aw_last_addr;
    logic [3:0]           r_wlen, r_wbeat;
    logic [2:0]           r_wsize;
    burst_type_t          r_wburst;
    logic                 r_wdec, r_wproto;
    resp_type_t           r_bresp, w_bresp_final;
    logic                 w_aw_hs, w_w_hs, w_wlast_beat, w_beat_proto, w_whard, w_we, w_aw_dec;

    assign o_awready    = (r_wstate == W_IDLE) && r_hs_enable;
    assign o_wready     = (r_wstate == W_DATA);
    assign o_bvalid     = (r_wstate == W_RESP);
    assign o_bid        = r_wid;
    assign o_bresp      = r_bresp;
    assign w_aw_hs      = o_awready && i_awvalid;
    assign w_w_hs       = o_wready && i_wvalid;
    assign w_wlast_beat = (r_wbeat == r_wlen);
    assign w_beat_proto = (i_wid != r_wid) || (i_wlast != w_wlast_beat);
    assign w_whard      = burst_is_illegal(r_wlen, r_wsize, MAX_SIZE, r_wburst);
    assign w_we         = w_w_hs && !r_wdec && !w_whard;

    // Range check covers the whole burst up front so an out-of-range burst
    // leaves memory untouched; FIXED/WRAP stay inside their first address region.
    assign w_aw_last_addr = i_awaddr + (ADDR_BITS'(i_awlen) << i_awsize);
    assign w_aw_dec       = f_oor(i_awaddr) || ((i_awburst == BURST_INCR) && f_oor(w_aw_last_addr));

    always_comb begin
        w_bresp_final = RESP_OKAY;
        if (r_wdec)                                    w_bresp_final = RESP_DECERR;
        else if (w_whard || r_wproto || w_beat_proto)  w_bresp_final = RESP_SLVERR;
    end

    amba3_axi_burst_addr #(.ADDR_BITS(ADDR_BITS)) u_waddr (
        .i_addr(r_waddr), .i_len(r_wlen), .i_size(r_wsize), .i_burst(r_wburst),
        .i_step(w_w_hs), .o_next_addr(w_wnext)
    );

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_next = W_RESP;
            W_RESP:  if (i_bready) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_wstate <= W_IDLE;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= BURST_FIXED;
            r_wbeat  <= '0;
            r_wdec   <= 1'b0;
            r_wproto <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_aw_hs) begin
                r_wid    <= i_awid;
                r_waddr  <= i_awaddr;
                r_wlen   <= i_awlen;
                r_wsize  <= i_awsize;
                r_wburst <= i_awburst;
                r_wbeat  <= '0;
                r_wdec   <= w_aw_dec;
                r_wproto <= 1'b0;
            end
            if (w_w_hs) begin
                r_waddr  <= w_wnext;
                r_wbeat  <= r_wbeat + 4'd1;
                r_wproto <= r_wproto | w_beat_proto;
                if (w_wlast_beat) r_bresp <= w_bresp_final;
            end
        end
    end

    // NOTE: the RAM has no reset branch; its contents survive reset and the array maps onto block RAM.
    always_ff @(posedge i_aclk) begin
        if (w_we) begin
            for (int b = 0; b < STRB_BITS; b++) begin
                if (i_wstrb[b]) r_mem[f_idx(r_waddr)][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t            r_rstate, w_rstate_next;
    logic [ADDR_BITS-1:0] r_raddr, w_rnext, w_rl_addr;
    logic [3:0]           r_rlen, r_rbeat, w_rl_len;
    logic [2:0]           r_rsize, w_rl_size;
    burst_type_t          r_rburst, w_rl_burst;
    logic [TXID_BITS-1:0] r_rid;
    logic [DATA_BITS-1:0] r_rdata, w_rl_data;
    resp_type_t           r_rresp, w_rl_resp;
    logic                 r_rlast, w_ar_hs, w_r_hs;

    assign o_arready = (r_rstate == R_IDLE) && r_hs_enable;
    assign o_rvalid  = (r_rstate == R_DATA);
    assign o_rid     = r_rid;
    assign o_rdata   = r_rdata;
    assign o_rresp   = r_rresp;
    assign o_rlast   = r_rlast;
    assign w_ar_hs   = o_arready && i_arvalid;
    assign w_r_hs    = o_rvalid && i_rready;

    amba3_axi_burst_addr #(.ADDR_BITS(ADDR_BITS)) u_raddr (
        .i_addr(r_raddr), .i_len(r_rlen), .i_size(r_rsize), .i_burst(r_rburst),
        .i_step(w_r_hs), .o_next_addr(w_rnext)
    );

    // The beat about to be loaded into the R registers: the AR request itself
    // when idle, otherwise the next beat of the current burst.
    assign w_rl_addr  = (r_rstate == R_IDLE) ? i_araddr  : w_rnext;
    assign w_rl_len   = (r_rstate == R_IDLE) ? i_arlen   : r_rlen;
    assign w_rl_size  = (r_rstate == R_IDLE) ? i_arsize  : r_rsize;
    assign w_rl_burst = (r_rstate == R_IDLE) ? i_arburst : r_rburst;

    always_comb begin
        w_rl_resp = RESP_OKAY;
        w_rl_data = r_mem[f_idx(w_rl_addr)];
        if (f_oor(w_rl_addr)) begin
            w_rl_resp = RESP_DECERR;
            w_rl_data = '0;
        end else if (burst_is_illegal(w_rl_len, w_rl_size, MAX_SIZE, w_rl_burst)) begin
            w_rl_resp = RESP_SLVERR;
            w_rl_data = '0;
        end
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_next = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= BURST_FIXED;
            r_rbeat  <= '0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rid    <= i_arid;
                r_raddr  <= i_araddr;
                r_rlen   <= i_arlen;
                r_rsize  <= i_arsize;
                r_rburst <= i_arburst;
                r_rbeat  <= '0;
                r_rlast  <= (i_arlen == 4'd0);
                r_rdata  <= w_rl_data;
                r_rresp  <= w_rl_resp;
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_raddr <= w_rnext;
                    r_rbeat <= r_rbeat + 4'd1;
                    r_rlast <= ((r_rbeat + 4'd1) == r_rlen);
                    r_rdata <= w_rl_data;
                    r_rresp <= w_rl_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_amba3_axi_ram_slave.sv
// Directed self-checking bench for amba3_axi_ram_slave (32-bit data, 1024 words).
module tb_amba3_axi_ram_slave;
    import pkg_amba3::*;

    logic        clk, rst_n;
    logic [3:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    burst_type_t awburst, arburst;
    lock_type_t  awlock, arlock;
    cache_t      awcache, arcache;
    prot_t       awprot, arprot;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    resp_type_t  bresp, rresp;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];

    amba3_axi_ram_slave dut (
        .i_aclk(clk), .i_areset_n(rst_n),
        .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
        .i_awburst(awburst), .i_awlock(awlock), .i_awcache(awcache), .i_awprot(awprot),
        .i_awvalid(awvalid), .o_awready(awready),
        .i_wid(wid), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast),
        .i_wvalid(wvalid), .o_wready(wready),
        .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
        .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
        .i_arburst(arburst), .i_arlock(arlock), .i_arcache(arcache), .i_arprot(arprot),
        .i_arvalid(arvalid), .o_arready(arready),
        .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast),
        .o_rvalid(rvalid), .i_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input burst_type_t burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        check("aw_ready", 128'(awready), 128'(1));
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
        int n = 0;
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        while (!wready && n < 50) begin @(posedge clk); #1; n++; end
        check("w_ready", 128'(wready), 128'(1));
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input resp_type_t resp, input int delay);
        int n = 0;
        bready = 1'b0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        check("b_valid", 128'(bvalid), 128'(1));
        repeat (delay) begin
            @(posedge clk); #1;
            check("b_hold", 128'(bvalid), 128'(1));
        end
        check("b_id", 128'(bid), 128'(id));
        check("b_resp", 128'(bresp), 128'(resp));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b_drop", 128'(bvalid), 128'(0));
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                               input burst_type_t burst, input logic [31:0] d0, input logic [3:0] strb,
                               input int last_beat, input resp_type_t resp, input int b_delay);
        do_aw(id, addr, len, 3'd2, burst);
        for (int i = 0; i <= int'(len); i++) do_w(id, d0 + 32'(i), strb, i == last_beat);
        do_b(id, resp, b_delay);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input burst_type_t burst, input bit toggle);
        int n = 0;
        int cyc = 0;
        int w = 0;
        bit tog = 1'b0;
        logic [38:0] snap;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        while (!arready && w < 50) begin @(posedge clk); #1; w++; end
        check("ar_ready", 128'(arready), 128'(1));
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("r_first_latency", 128'(rvalid), 128'(1));
        while (n <= int'(len) && cyc < 200) begin
            rready = toggle ? tog : 1'b1;
            tog = !tog;
            if (rvalid && !rready) begin
                snap = {rid, rdata, rresp, rlast};
                @(posedge clk); #1; cyc++;
                check("r_stall_stable", 128'({rid, rdata, rresp, rlast}), 128'(snap));
            end else begin
                if (rvalid) begin
                    got_id[n] = rid; got_data[n] = rdata; got_resp[n] = rresp; got_last[n] = rlast;
                    n++;
                end
                @(posedge clk); #1; cyc++;
            end
        end
        rready = 1'b0;
        check("r_beat_count", 128'(n), 128'(int'(len) + 1));
        check("r_valid_drop", 128'(rvalid), 128'(0));
        if (!toggle) check("r_back_to_back", 128'(cyc), 128'(int'(len) + 1));
    endtask

    task automatic expect_beat(input string tag, input int i, input logic [31:0] data,
                               input resp_type_t resp, input logic last);
        check({tag, "_data"}, 128'(got_data[i]), 128'(data));
        check({tag, "_resp"}, 128'(got_resp[i]), 128'(resp));
        check({tag, "_last"}, 128'(got_last[i]), 128'(last));
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = BURST_FIXED;
        awlock = LOCK_NORMAL; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = BURST_FIXED;
        arlock = LOCK_NORMAL; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_valid", 128'({awready, wready, arready, bvalid, rvalid}), 128'(0));
        check("rst_ids_data", 128'({bid, rid, rdata}), 128'(0));
        check("rst_resp_last", 128'({bresp, rresp, rlast}), 128'(0));
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // W beats are not accepted before AW
        wvalid = 1'b1; wid = 4'd0;
        @(posedge clk); #1;
        check("w_before_aw", 128'(wready), 128'(0));
        wvalid = 1'b0;

        // INCR write then read back
        write_burst(4'd3, 32'h100, 4'd3, BURST_INCR, 32'd1, 4'hF, 3, RESP_OKAY, 0);
        read_burst(4'd5, 32'h100, 4'd3, 3'd2, BURST_INCR, 1'b0);
        check("incr_rid", 128'(got_id[0]), 128'(5));
        for (int i = 0; i < 4; i++) expect_beat("incr", i, 32'(i + 1), RESP_OKAY, i == 3);

        // WRAP read: 0x10C, 0x100, 0x104, 0x108
        read_burst(4'd6, 32'h10C, 4'd3, 3'd2, BURST_WRAP, 1'b0);
        expect_beat("wrap0", 0, 32'd4, RESP_OKAY, 1'b0);
        expect_beat("wrap1", 1, 32'd1, RESP_OKAY, 1'b0);
        expect_beat("wrap2", 2, 32'd2, RESP_OKAY, 1'b0);
        expect_beat("wrap3", 3, 32'd3, RESP_OKAY, 1'b1);

        // Strobe merge, with B held off for 5 cycles on the second write
        write_burst(4'd1, 32'h200, 4'd0, BURST_INCR, 32'hAABBCCDD, 4'hF, 0, RESP_OKAY, 0);
        write_burst(4'd2, 32'h200, 4'd0, BURST_INCR, 32'h11223344, 4'h5, 0, RESP_OKAY, 5);
        read_burst(4'd2, 32'h200, 4'd0, 3'd2, BURST_INCR, 1'b0);
        expect_beat("strb", 0, 32'hAA22CC44, RESP_OKAY, 1'b1);

        // Out-of-range write: DECERR and no aliasing into word 0
        write_burst(4'd4, 32'h0, 4'd0, BURST_INCR, 32'h12345678, 4'hF, 0, RESP_OKAY, 0);
        write_burst(4'd4, 32'h1000, 4'd0, BURST_INCR, 32'hDEAD0000, 4'hF, 0, RESP_DECERR, 0);
        read_burst(4'd1, 32'h0, 4'd0, 3'd2, BURST_INCR, 1'b0);
        expect_beat("decerr_mem", 0, 32'h12345678, RESP_OKAY, 1'b1);
        read_burst(4'd1, 32'h1000, 4'd0, 3'd2, BURST_INCR, 1'b0);
        check("decerr_read", 128'(got_resp[0]), 128'(RESP_DECERR));

        // Oversize read: SLVERR on every beat
        read_burst(4'd7, 32'h100, 4'd1, 3'd3, BURST_INCR, 1'b0);
        check("size_err0", 128'(got_resp[0]), 128'(RESP_SLVERR));
        check("size_err1", 128'(got_resp[1]), 128'(RESP_SLVERR));

        // Early wlast on beat 1: SLVERR after 4 beats, data still written
        write_burst(4'd7, 32'h300, 4'd3, BURST_INCR, 32'h30, 4'hF, 1, RESP_SLVERR, 0);
        read_burst(4'd7, 32'h300, 4'd3, 3'd2, BURST_INCR, 1'b0);
        for (int i = 0; i < 4; i++) expect_beat("early_last", i, 32'h30 + 32'(i), RESP_OKAY, i == 3);

        // rready toggling every cycle
        read_burst(4'd8, 32'h100, 4'd3, 3'd2, BURST_INCR, 1'b1);
        for (int i = 0; i < 4; i++) expect_beat("bp", i, 32'(i + 1), RESP_OKAY, i == 3);

        // Reset in the middle of a len-7 write
        do_aw(4'd9, 32'h400, 4'd7, 3'd2, BURST_INCR);
        do_w(4'd9, 32'h50, 4'hF, 1'b0);
        do_w(4'd9, 32'h51, 4'hF, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_ready_valid", 128'({awready, wready, arready, bvalid, rvalid}), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_no_bresp", 128'(bvalid), 128'(0));
        write_burst(4'd10, 32'h480, 4'd1, BURST_INCR, 32'h60, 4'hF, 1, RESP_OKAY, 0);
        read_burst(4'd10, 32'h400, 4'd1, 3'd2, BURST_INCR, 1'b0);
        expect_beat("kept0", 0, 32'h50, RESP_OKAY, 1'b0);
        expect_beat("kept1", 1, 32'h51, RESP_OKAY, 1'b1);
        read_burst(4'd10, 32'h480, 4'd1, 3'd2, BURST_INCR, 1'b0);
        expect_beat("after0", 0, 32'h60, RESP_OKAY, 1'b0);
        expect_beat("after1", 1, 32'h61, RESP_OKAY, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
